regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port between two requesters:
  - the writeback stage (WB result, already gated by RegWrite and Move);
  - the decode-stage jump-and-link return-address write (PC+4 into $31).
- Simultaneous requests no longer collide. The loser is held in a small in-order pending queue and drained one write per cycle.
- A combinational lookup port lets decode reads see pending writes, and a Stall output throttles decode when the queue nears full.
- Sits between the writeback mux / decode controller and the RegisterFile write inputs.

---
 rtl/regfile_write_arbiter.sv | 173 +++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register-file write port between writeback and the JAL link write.
// Losing requests wait in an in-order pending queue; the lookup ports expose in-flight writes to decode.
module regfile_write_arbiter #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              WbValid,
    input  logic [ADDR_W-1:0] WbReg,
    input  logic [DATA_W-1:0] WbData,
    input  logic              LinkValid,
    input  logic [DATA_W-1:0] LinkData,
    input  logic [ADDR_W-1:0] LookupReg1,
    input  logic [ADDR_W-1:0] LookupReg2,
    output logic              LookupHit1,
    output logic [DATA_W-1:0] LookupData1,
    output logic              LookupHit2,
    output logic [DATA_W-1:0] LookupData2,
    output logic              RfWrite,
    output logic [ADDR_W-1:0] RfWriteRegister,
    output logic [DATA_W-1:0] RfWriteData,
    output logic              Stall,
    output logic [3:0]        Count,
    output logic              Overflow
);

    localparam int unsigned       PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [3:0]        DEPTH_CNT = 4'(DEPTH);
    localparam logic [ADDR_W-1:0] LINK_REG  = ADDR_W'(31);

    logic [ADDR_W-1:0] q_reg  [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  link_slot;
    logic [3:0]        count;
    logic [3:0]        space;
    logic [3:0]        link_need;
    logic              overflow;

    logic wb_req;
    logic link_req;
    logic pop;
    logic grant_wb;
    logic grant_link;
    logic wb_pend;
    logic link_pend;
    logic push_wb;
    logic push_link;
    logic overflow_set;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Requests are masked while reset is held so no write or lookup hit escapes during reset.
    always_comb begin
        wb_req       = Rst && WbValid && (WbReg != '0);
        link_req     = Rst && LinkValid;
        pop          = (count != '0);
        grant_wb     = !pop && wb_req;
        grant_link   = !pop && !wb_req && link_req;
        wb_pend      = wb_req && !grant_wb;
        link_pend    = link_req && !grant_link;
        space        = DEPTH_CNT - count + 4'(pop);
        push_wb      = wb_pend && (space != '0);
        link_need    = push_wb ? 4'd2 : 4'd1;
        push_link    = link_pend && (space >= link_need);
        link_slot    = push_wb ? next_ptr(tail) : tail;
        overflow_set = (wb_pend && !push_wb) || (link_pend && !push_link) || (link_req && Stall);
    end

    always_comb begin
        RfWrite         = 1'b0;
        RfWriteRegister = '0;
        RfWriteData     = '0;
        if (pop) begin
            RfWrite         = 1'b1;
            RfWriteRegister = q_reg[head];
            RfWriteData     = q_data[head];
        end else if (grant_wb) begin
            RfWrite         = 1'b1;
            RfWriteRegister = WbReg;
            RfWriteData     = WbData;
        end else if (grant_link) begin
            RfWrite         = 1'b1;
            RfWriteRegister = LINK_REG;
            RfWriteData     = LinkData;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) begin
                head <= next_ptr(head);
            end
            if (push_wb && push_link) begin
                tail <= next_ptr(next_ptr(tail));
            end else if (push_wb || push_link) begin
                tail <= next_ptr(tail);
            end
            count <= count - 4'(pop) + 4'(push_wb) + 4'(push_link);
            if (overflow_set) begin
                overflow <= 1'b1;
            end
        end
    end

    // Entry storage needs no reset: only the count window of entries is ever read.
    always_ff @(posedge Clk) begin
        if (push_wb) begin
            q_reg[tail]  <= WbReg;
            q_data[tail] <= WbData;
        end
        if (push_link) begin
            q_reg[link_slot]  <= LINK_REG;
            q_data[link_slot] <= LinkData;
        end
    end

    // Each lookup scans oldest to newest so the last match left standing is the newest one.
    for (genvar g = 0; g < 2; g++) begin : g_lookup
        logic [ADDR_W-1:0] idx;
        logic              hit;
        logic [DATA_W-1:0] data;

        assign idx = (g == 0) ? LookupReg1 : LookupReg2;

        always_comb begin
            logic [PTR_W-1:0] p;
            hit  = 1'b0;
            data = '0;
            p    = head;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if ((4'(i) < count) && (q_reg[p] == idx)) begin
                    hit  = 1'b1;
                    data = q_data[p];
                end
                p = next_ptr(p);
            end
            if (wb_req && (WbReg == idx)) begin
                hit  = 1'b1;
                data = WbData;
            end
            if (link_req && (LINK_REG == idx)) begin
                hit  = 1'b1;
                data = LinkData;
            end
            if (idx == '0) begin
                hit  = 1'b0;
                data = '0;
            end
        end
    end

    assign LookupHit1  = g_lookup[0].hit;
    assign LookupData1 = g_lookup[0].data;
    assign LookupHit2  = g_lookup[1].hit;
    assign LookupData2 = g_lookup[1].data;

    assign Stall    = (count >= DEPTH_CNT - 4'd1);
    assign Count    = count;
    assign Overflow = overflow;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (DEPTH=2): grant order, queueing, lookup, stall, overflow, reset.
module tb_regfile_write_arbiter;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        WbValid = 1'b0;
    logic [4:0]  WbReg = '0;
    logic [31:0] WbData = '0;
    logic        LinkValid = 1'b0;
    logic [31:0] LinkData = '0;
    logic [4:0]  LookupReg1 = '0;
    logic [4:0]  LookupReg2 = '0;
    logic        LookupHit1;
    logic [31:0] LookupData1;
    logic        LookupHit2;
    logic [31:0] LookupData2;
    logic        RfWrite;
    logic [4:0]  RfWriteRegister;
    logic [31:0] RfWriteData;
    logic        Stall;
    logic [3:0]  Count;
    logic        Overflow;

    int checks = 0;
    int failures = 0;

    regfile_write_arbiter #(.DEPTH(2), .DATA_W(32), .ADDR_W(5)) dut (
        .Clk(Clk), .Rst(Rst),
        .WbValid(WbValid), .WbReg(WbReg), .WbData(WbData),
        .LinkValid(LinkValid), .LinkData(LinkData),
        .LookupReg1(LookupReg1), .LookupReg2(LookupReg2),
        .LookupHit1(LookupHit1), .LookupData1(LookupData1),
        .LookupHit2(LookupHit2), .LookupData2(LookupData2),
        .RfWrite(RfWrite), .RfWriteRegister(RfWriteRegister), .RfWriteData(RfWriteData),
        .Stall(Stall), .Count(Count), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Apply one cycle of requests at the falling edge and settle before sampling.
    task automatic drive(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                         input logic lv, input logic [31:0] ld);
        @(negedge Clk);
        WbValid   = wv;
        WbReg     = wr;
        WbData    = wd;
        LinkValid = lv;
        LinkData  = ld;
        #1;
    endtask

    task automatic check_write(input string tag, input logic we, input logic [4:0] r, input logic [31:0] d);
        check({tag, ".we"}, 32'(RfWrite), 32'(we));
        if (we) begin
            check({tag, ".reg"}, 32'(RfWriteRegister), 32'(r));
            check({tag, ".data"}, RfWriteData, d);
        end
    endtask

    initial begin
        // Reset state
        drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        check("rst.count", 32'(Count), 32'd0);
        check("rst.rfwrite", 32'(RfWrite), 32'd0);
        check("rst.stall", 32'(Stall), 32'd0);
        check("rst.overflow", 32'(Overflow), 32'd0);
        check("rst.hit1", 32'(LookupHit1), 32'd0);
        @(negedge Clk);
        Rst = 1'b1;

        // Zero-latency WB write with empty queue
        LookupReg1 = 5'd5;
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0);
        check_write("wb0", 1'b1, 5'd5, 32'hDEADBEEF);
        check("wb0.hit1", 32'(LookupHit1), 32'd1);
        check("wb0.data1", LookupData1, 32'hDEADBEEF);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        check("wb0.count", 32'(Count), 32'd0);
        check_write("idle0", 1'b0, 5'd0, 32'h0);

        // Simultaneous WB + Link: WB first, Link one cycle later
        LookupReg1 = 5'd31;
        drive(1'b1, 5'd7, 32'h11, 1'b1, 32'h00400008);
        check_write("pair.n", 1'b1, 5'd7, 32'h11);
        check("pair.n.hit31", 32'(LookupHit1), 32'd1);
        check("pair.n.data31", LookupData1, 32'h00400008);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        check("pair.n1.count", 32'(Count), 32'd1);
        check("pair.n1.stall", 32'(Stall), 32'd1);
        check_write("pair.n1", 1'b1, 5'd31, 32'h00400008);
        check("pair.n1.hit31", 32'(LookupHit1), 32'd1);
        check("pair.n1.data31", LookupData1, 32'h00400008);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        check("pair.n2.count", 32'(Count), 32'd0);
        check("pair.n2.stall", 32'(Stall), 32'd0);
        check_write("pair.n2", 1'b0, 5'd0, 32'h0);

        // Register 0 is filtered
        LookupReg1 = 5'd0;
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 32'h0);
        check_write("r0", 1'b0, 5'd0, 32'h0);
        check("r0.hit1", 32'(LookupHit1), 32'd0);
        check("r0.data1", LookupData1, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        check("r0.count", 32'(Count), 32'd0);

        // Back-to-back traffic with Link held low under Stall
        drive(1'b1, 5'd1, 32'hA1, 1'b1, 32'hB1);
        check_write("b2b.a", 1'b1, 5'd1, 32'hA1);
        LookupReg1 = 5'd31;
        drive(1'b1, 5'd2, 32'hA2, 1'b0, 32'h0);
        check("b2b.b.count", 32'(Count), 32'd1);
        check("b2b.b.stall", 32'(Stall), 32'd1);
        check_write("b2b.b", 1'b1, 5'd31, 32'hB1);
        check("b2b.b.hit31", 32'(LookupHit1), 32'd1);
        check("b2b.b.data31", LookupData1, 32'hB1);
        LookupReg2 = 5'd2;
        drive(1'b1, 5'd2, 32'hA3, 1'b0, 32'h0);
        check("b2b.c.count", 32'(Count), 32'd1);
        check_write("b2b.c", 1'b1, 5'd2, 32'hA2);
        check("b2b.c.hit2", 32'(LookupHit2), 32'd1);
        check("b2b.c.newest2", LookupData2, 32'hA3);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        check("b2b.d.count", 32'(Count), 32'd1);
        check_write("b2b.d", 1'b1, 5'd2, 32'hA3);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        check("b2b.e.count", 32'(Count), 32'd0);
        check("b2b.e.overflow", 32'(Overflow), 32'd0);

        // Link during Stall: overflow flagged, request still queued while space remains
        drive(1'b1, 5'd4, 32'hC4, 1'b1, 32'hD4);
        check_write("ovf.e", 1'b1, 5'd4, 32'hC4);
        drive(1'b1, 5'd6, 32'hC6, 1'b1, 32'hD6);
        check("ovf.f.overflow_pre", 32'(Overflow), 32'd0);
        check_write("ovf.f", 1'b1, 5'd31, 32'hD4);
        LookupReg2 = 5'd6;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 32'hE6);
        check("ovf.g.count", 32'(Count), 32'd2);
        check("ovf.g.overflow", 32'(Overflow), 32'd1);
        check("ovf.g.stall", 32'(Stall), 32'd1);
        check_write("ovf.g", 1'b1, 5'd6, 32'hC6);
        check("ovf.g.data31", LookupData1, 32'hE6);
        check("ovf.g.data6", LookupData2, 32'hC6);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        check("ovf.h.count", 32'(Count), 32'd2);
        check_write("ovf.h", 1'b1, 5'd31, 32'hD6);
        check("ovf.h.newest31", LookupData1, 32'hE6);
        check("ovf.h.hit6", 32'(LookupHit2), 32'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        check_write("ovf.i", 1'b1, 5'd31, 32'hE6);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        check("ovf.j.count", 32'(Count), 32'd0);
        check("ovf.j.sticky", 32'(Overflow), 32'd1);

        // Asynchronous reset with two queued entries
        drive(1'b1, 5'd8, 32'h88, 1'b1, 32'h99);
        LookupReg1 = 5'd9;
        drive(1'b1, 5'd9, 32'h77, 1'b1, 32'h66);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        check("arst.pre.count", 32'(Count), 32'd2);
        #2;
        Rst = 1'b0;
        #1;
        check("arst.count", 32'(Count), 32'd0);
        check("arst.rfwrite", 32'(RfWrite), 32'd0);
        check("arst.stall", 32'(Stall), 32'd0);
        check("arst.overflow", 32'(Overflow), 32'd0);
        check("arst.hit9", 32'(LookupHit1), 32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        check("arst.post0.rfwrite", 32'(RfWrite), 32'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        check("arst.post1.rfwrite", 32'(RfWrite), 32'd0);
        check("arst.post1.count", 32'(Count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
